// File: rtl/tc_psum_collector.sv
// Partial-sum collector: feeds intermediate psums back to the tensor core and queues final tile
// results in a small output FIFO. Optional macro PSUM_RELU_EN clamps negative final lanes to 0.
module tc_psum_collector #(
    parameter int unsigned LANES      = 16,
    parameter int unsigned PSUM_W     = 32,
    parameter int unsigned K_STEPS_W  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [K_STEPS_W-1:0]      cfg_k_steps,
    input  logic [LANES*PSUM_W-1:0]   result_in,
    input  logic                      result_valid,
    output logic                      stall,
    output logic [LANES*PSUM_W-1:0]   psum_data_out,
    output logic                      psum_update,
    output logic [LANES*PSUM_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      protocol_err
);

    localparam int unsigned W     = LANES * PSUM_W;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e               state_q;
    logic [K_STEPS_W-1:0] step_q;
    logic [K_STEPS_W-1:0] n_q;

    logic [W-1:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    logic                 fifo_full;
    logic                 last_step;
    logic                 push;
    logic                 pop;
    logic [W-1:0]         push_data;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign last_step = (step_q == n_q - K_STEPS_W'(1));
    assign stall     = (state_q == StAccum) && last_step && fifo_full;
    assign busy      = (state_q == StAccum);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;
    // start takes priority over a result arriving in the same cycle
    assign push      = !start && result_valid && (state_q == StAccum) && last_step && !fifo_full;

    always_comb begin
        push_data = result_in;
`ifdef PSUM_RELU_EN
        for (int unsigned i = 0; i < LANES; i++) begin
            if (result_in[i*PSUM_W + PSUM_W - 1]) begin
                push_data[i*PSUM_W +: PSUM_W] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= StIdle;
            step_q        <= '0;
            n_q           <= K_STEPS_W'(1);
            psum_data_out <= '0;
            psum_update   <= 1'b0;
            tile_done     <= 1'b0;
            protocol_err  <= 1'b0;
        end else begin
            psum_update <= 1'b0;
            tile_done   <= 1'b0;
            if (start) begin
                n_q           <= (cfg_k_steps == '0) ? K_STEPS_W'(1) : cfg_k_steps;
                step_q        <= '0;
                state_q       <= StAccum;
                psum_data_out <= '0;
                psum_update   <= 1'b1;
                protocol_err  <= 1'b0;
            end else if (result_valid) begin
                if (state_q == StIdle || stall) begin
                    protocol_err <= 1'b1;
                end else if (last_step) begin
                    psum_data_out <= '0;
                    psum_update   <= 1'b1;
                    tile_done     <= 1'b1;
                    state_q       <= StIdle;
                end else begin
                    psum_data_out <= result_in;
                    psum_update   <= 1'b1;
                    step_q        <= step_q + K_STEPS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
